ahb_mul_accel: RTL and testbench
================================

# ahb_mul_accel

Parametrised AHB-Lite slave multiplier for the Gowin EMPU fabric. It is the successor to the fixed 8-bit repeated-addition multiplier and sits on the same AHB expansion port, decoded by `AHB_HSEL`. It performs a `WIDTH`×`WIDTH` shift-add multiply in signed or unsigned mode, with fixed latency. It reports completion through a sticky status bit and an optional level interrupt.

## Interface
Parameters:
- `WIDTH`, default 16: operand width, legal 2..32; the product is 2·`WIDTH` bits.

Ports (all AHB slave signals are present; `HTRANS[0]`, `HBURST`, `HPROT`, `HSIZE`, `HMASTLOCK` and `HMASTER` are ignored):
- `AHB_HCLK` in 1: the single clock.
- `AHB_HRESET` in 1: reset, synchronous, active-high.
- `AHB_HSEL` in 1: slave select.
- `AHB_HTRANS` in 2: only bit1 (NONSEQ/SEQ) is used.
- `AHB_HWRITE` in 1: write when high.
- `AHB_HADDR` in 32: only bits [15:0] are decoded.
- `AHB_HWDATA` in 32: write data, sampled in the data phase.
- `AHB_HRDATA` out 32: read data.
- `AHB_HREADY` out 1: tied to 1.
- `AHB_HRESP` out 2: tied to 0 (OKAY).
- `MUL_IRQ` out 1: level interrupt, defined as DONE & IRQ_EN.

## Operation
- Address phase registered: captures HADDR[15:0], HWRITE, HSEL and HTRANS[1]. The data phase is one cycle later.
  - wr_en = the registered HTRANS[1], HWRITE and HSEL are all set.
  - rd_en = the registered HTRANS[1] and HSEL are set and HWRITE is clear.
- Register map:
  - 0x00 OPA: [`WIDTH`-1:0], R/W.
  - 0x04 OPB: [`WIDTH`-1:0], R/W.
  - 0x08 CTRL/STATUS:
    - bit0 START: write-1 to start; always reads 0.
    - bit1 DONE: sticky; cleared by writing 1 to it.
    - bit2 BUSY: read-only.
    - bit3 SIGNED: R/W.
    - bit4 IRQ_EN: R/W.
    - bit5 ACC: see Configuration.
  - 0x0C RES_LO: product[31:0], read-only.
  - 0x10 RES_HI: product[2·`WIDTH`-1:32], read-only; reads 0 when `WIDTH` ≤ 16.
- Register reads:
  - Unused bits read 0.
  - Unmapped addresses read 0xFFFFFFFF.
  - HRDATA = 0 when rd_en is low.
- FSM states IDLE, LOAD, RUN, FIN:
  - IDLE→LOAD on a START write. The same CTRL write also updates SIGNED, IRQ_EN, ACC and clears DONE if its bit1=1. A START write also clears DONE regardless of bit1.
  - LOAD, 1 cycle:
    - If SIGNED, capture the magnitudes of OPA and OPB and set neg = OPA[msb] ^ OPB[msb]; otherwise capture the raw values with neg = 0.
    - Clear the partial product and set the bit counter to 0.
  - RUN, `WIDTH` cycles: if multiplier bit[k] is 1, add the multiplicand shifted left by k. The counter increments. Exit after k = `WIDTH`-1.
  - FIN, 1 cycle:
    - Form the result as the partial product, two's-complement negated if neg.
    - Write it (or add it; see ACC) into the 2·`WIDTH`-bit RES register.
    - Set DONE and return to IDLE.
- BUSY = 1 in LOAD, RUN and FIN.
- Arithmetic:
  - The signed minimum operand is handled: its magnitude 2^(`WIDTH`-1) fits in `WIDTH` unsigned bits.
  - (-2^(W-1))² = 2^(2W-2) fits in the 2W-bit result.
  - RES is not sign-extended past 2·`WIDTH` bits.
- While BUSY:
  - Writes to OPA, OPB and CTRL are ignored, except the DONE clear.
  - Reads return live values; RES holds the previous result until FIN.
- A DONE clear and DONE being set by FIN in the same cycle: the set wins.
- Reset mid-operation: the FSM goes to IDLE and all registers are cleared; no DONE is produced.

## Timing
- Reset values:
  - OPA, OPB, CTRL and RES are all 0; the FSM is in IDLE.
  - `MUL_IRQ` = 0 and `AHB_HRDATA` = 0.
- A START write takes effect at the clock edge ending its data phase (call this edge E).
  - BUSY reads 1 from edge E onward.
  - DONE, `MUL_IRQ` and the new RES are visible after edge E + `WIDTH` + 2 (LOAD + `WIDTH`×RUN + FIN).
  - BUSY falls at the same edge that DONE rises.
- Back-to-back operations: a new START is accepted on the first data-phase write after BUSY falls.
- Zero wait states; HREADY is always 1.

## Configuration
- Macro `MUL_ACCEL_ACCUMULATE_EN`.
- Defined:
  - CTRL bit5 ACC is R/W.
  - When ACC=1, FIN performs RES ← RES + signed/unsigned product, modulo 2^(2·`WIDTH`).
  - Writing RES_LO clears the full RES register, in IDLE only.
- Undefined:
  - bit5 reads 0 and writes to it are ignored.
  - FIN always overwrites RES.
  - Writes to RES_LO are ignored.

## Test plan
- Reset, then read all registers: 0x00, 0x04, 0x08, 0x0C and 0x10 read 0; 0x14 reads 0xFFFFFFFF; `MUL_IRQ`=0.
- `WIDTH`=16, unsigned: OPA=3, OPB=5, write CTRL=0x01 → BUSY=1 for 18 cycles; then DONE=1 and RES_LO=0x0000000F.
- `WIDTH`=16, signed: OPA=0xFFFD (-3), OPB=5, CTRL=0x19 → RES_LO=0xFFFFFFF1 and RES_HI=0; `MUL_IRQ`=1 until CTRL is written with 0x12 (DONE clear plus IRQ_EN kept), after which `MUL_IRQ`=0.
- `WIDTH`=32, signed corner case: OPA=OPB=0x80000000 → RES_HI=0x40000000, RES_LO=0. Unsigned 0xFFFFFFFF×0xFFFFFFFF → RES_HI=0xFFFFFFFE, RES_LO=0x00000001.
- During BUSY, write OPA=7 and write START: OPA is unchanged, there is one DONE only, and RES comes from the original operands. A reset asserted in RUN leaves DONE=0 and BUSY=0 on the next cycle.
- With the `_EN` macro defined, `WIDTH`=16: two runs 3×5 with ACC=1 → RES_LO=0x1E. A RES_LO write in IDLE → RES_LO=0.

Source files
------------

// File: rtl/ahb_mul_accel.sv
// ahb_mul_accel: AHB-Lite slave WIDTH x WIDTH shift-add multiplier.
// Signed or unsigned mode, fixed latency of WIDTH+2 cycles, sticky DONE bit and
// a level interrupt (DONE & IRQ_EN).
// Optional feature macro: MUL_ACCEL_ACCUMULATE_EN (CTRL.ACC, RES accumulate,
// RES_LO write clears RES while idle).
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a START write; register writes accepted
// LOAD   | capture operand magnitudes and sign, clear partial product
// RUN    | one multiplier bit per cycle, WIDTH cycles
// FIN    | apply sign, write or accumulate RES, set DONE
module ahb_mul_accel #(
    parameter int WIDTH = 16
) (
    input  logic        AHB_HCLK,
    input  logic        AHB_HRESET,
    input  logic        AHB_HSEL,
    input  logic [1:0]  AHB_HTRANS,
    input  logic        AHB_HWRITE,
    input  logic [31:0] AHB_HADDR,
    input  logic [31:0] AHB_HWDATA,
    input  logic [2:0]  AHB_HBURST,
    input  logic [3:0]  AHB_HPROT,
    input  logic [2:0]  AHB_HSIZE,
    input  logic        AHB_HMASTLOCK,
    input  logic [3:0]  AHB_HMASTER,
    output logic [31:0] AHB_HRDATA,
    output logic        AHB_HREADY,
    output logic [1:0]  AHB_HRESP,
    output logic        MUL_IRQ
);

    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_FIN} state_t;

    state_t            state;
    logic [15:0]       ap_addr;
    logic              ap_write;
    logic              ap_sel;
    logic              ap_trans;
    logic              wr_en;
    logic              rd_en;
    logic              sel_opa, sel_opb, sel_ctrl, sel_reslo, sel_reshi;

    logic [WIDTH-1:0]  opa;
    logic [WIDTH-1:0]  opb;
    logic              signed_mode;
    logic              irq_en;
    logic              acc_mode;
    logic              done;
    logic              busy;
    logic [PW-1:0]     res;
    logic [63:0]       res_ext;

    logic [PW-1:0]     mcand;
    logic [WIDTH-1:0]  mplier;
    logic [PW-1:0]     pprod;
    logic              neg;
    logic [5:0]        cnt;

    logic [WIDTH-1:0]  mag_a;
    logic [WIDTH-1:0]  mag_b;
    logic [PW-1:0]     prod_final;

    // Pins this slave does not use; folded here so they are visibly consumed.
    logic unused_sig;
    assign unused_sig = ^{AHB_HTRANS[0], AHB_HADDR[31:16], AHB_HWDATA, AHB_HBURST,
                          AHB_HPROT, AHB_HSIZE, AHB_HMASTLOCK, AHB_HMASTER};

    assign AHB_HREADY = 1'b1;
    assign AHB_HRESP  = 2'b00;
    assign MUL_IRQ    = done & irq_en;
    assign busy       = (state != S_IDLE);

    assign wr_en     = ap_trans & ap_sel & ap_write;
    assign rd_en     = ap_trans & ap_sel & ~ap_write;
    assign sel_opa   = (ap_addr == 16'h0000);
    assign sel_opb   = (ap_addr == 16'h0004);
    assign sel_ctrl  = (ap_addr == 16'h0008);
    assign sel_reslo = (ap_addr == 16'h000C);
    assign sel_reshi = (ap_addr == 16'h0010);

    // Operand magnitudes; the signed minimum maps onto itself, which is the
    // correct unsigned magnitude 2^(WIDTH-1).
    assign mag_a = (signed_mode && opa[WIDTH-1]) ? (~opa + WIDTH'(1)) : opa;
    assign mag_b = (signed_mode && opb[WIDTH-1]) ? (~opb + WIDTH'(1)) : opb;
    assign prod_final = neg ? (~pprod + PW'(1)) : pprod;

`ifndef MUL_ACCEL_ACCUMULATE_EN
    assign acc_mode = 1'b0;
`endif

    // Register the address phase; the data phase follows one cycle later.
    always_ff @(posedge AHB_HCLK) begin
        if (AHB_HRESET) begin
            ap_addr  <= '0;
            ap_write <= 1'b0;
            ap_sel   <= 1'b0;
            ap_trans <= 1'b0;
        end else begin
            ap_addr  <= AHB_HADDR[15:0];
            ap_write <= AHB_HWRITE;
            ap_sel   <= AHB_HSEL;
            ap_trans <= AHB_HTRANS[1];
        end
    end

    // Sequencer plus register file: writes land only in IDLE, except DONE clear.
    always_ff @(posedge AHB_HCLK) begin
        if (AHB_HRESET) begin
            state       <= S_IDLE;
            opa         <= '0;
            opb         <= '0;
            signed_mode <= 1'b0;
            irq_en      <= 1'b0;
`ifdef MUL_ACCEL_ACCUMULATE_EN
            acc_mode    <= 1'b0;
`endif
            done        <= 1'b0;
            res         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            pprod       <= '0;
            neg         <= 1'b0;
            cnt         <= '0;
        end else begin
            // DONE clear while busy; a FIN set below overrides it.
            if (busy && wr_en && sel_ctrl && AHB_HWDATA[1])
                done <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (wr_en && sel_opa)
                        opa <= AHB_HWDATA[WIDTH-1:0];
                    if (wr_en && sel_opb)
                        opb <= AHB_HWDATA[WIDTH-1:0];
                    if (wr_en && sel_ctrl) begin
                        signed_mode <= AHB_HWDATA[3];
                        irq_en      <= AHB_HWDATA[4];
`ifdef MUL_ACCEL_ACCUMULATE_EN
                        acc_mode    <= AHB_HWDATA[5];
`endif
                        if (AHB_HWDATA[1] || AHB_HWDATA[0])
                            done <= 1'b0;
                        if (AHB_HWDATA[0])
                            state <= S_LOAD;
                    end
`ifdef MUL_ACCEL_ACCUMULATE_EN
                    if (wr_en && sel_reslo)
                        res <= '0;
`endif
                end
                S_LOAD: begin
                    mcand  <= {{WIDTH{1'b0}}, mag_a};
                    mplier <= mag_b;
                    neg    <= signed_mode & (opa[WIDTH-1] ^ opb[WIDTH-1]);
                    pprod  <= '0;
                    cnt    <= '0;
                    state  <= S_RUN;
                end
                S_RUN: begin
                    if (mplier[0])
                        pprod <= pprod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 6'd1;
                    if (cnt == 6'(WIDTH - 1))
                        state <= S_FIN;
                end
                S_FIN: begin
                    res   <= acc_mode ? (res + prod_final) : prod_final;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Zero-extend RES to 64 bits so RES_HI reads 0 for narrow widths.
    always_comb begin
        res_ext          = '0;
        res_ext[PW-1:0]  = res;
    end

    // Read mux, driven during the data phase of a read.
    always_comb begin
        AHB_HRDATA = '0;
        if (rd_en) begin
            if (sel_opa)
                AHB_HRDATA = 32'(opa);
            else if (sel_opb)
                AHB_HRDATA = 32'(opb);
            else if (sel_ctrl)
                AHB_HRDATA = {26'd0, acc_mode, irq_en, signed_mode, busy, done, 1'b0};
            else if (sel_reslo)
                AHB_HRDATA = res_ext[31:0];
            else if (sel_reshi)
                AHB_HRDATA = res_ext[63:32];
            else
                AHB_HRDATA = 32'hFFFF_FFFF;
        end
    end

endmodule

// File: tb/tb_ahb_mul_accel.sv
// Directed bench for ahb_mul_accel: one WIDTH=16 and one WIDTH=32 instance
// on a shared bus, selected by their own HSEL.
module tb_ahb_mul_accel;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel16 = 1'b0;
    logic        sel32 = 1'b0;
    logic [1:0]  trans = 2'b00;
    logic        write = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rd16, rd32;
    logic        rdy16, rdy32, irq16, irq32;
    logic [1:0]  resp16, resp32;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ahb_mul_accel #(.WIDTH(16)) u16 (
        .AHB_HCLK(clk), .AHB_HRESET(rst), .AHB_HSEL(sel16), .AHB_HTRANS(trans),
        .AHB_HWRITE(write), .AHB_HADDR(addr), .AHB_HWDATA(wdata),
        .AHB_HBURST(3'b000), .AHB_HPROT(4'b0011), .AHB_HSIZE(3'b010),
        .AHB_HMASTLOCK(1'b0), .AHB_HMASTER(4'h0),
        .AHB_HRDATA(rd16), .AHB_HREADY(rdy16), .AHB_HRESP(resp16), .MUL_IRQ(irq16)
    );

    ahb_mul_accel #(.WIDTH(32)) u32 (
        .AHB_HCLK(clk), .AHB_HRESET(rst), .AHB_HSEL(sel32), .AHB_HTRANS(trans),
        .AHB_HWRITE(write), .AHB_HADDR(addr), .AHB_HWDATA(wdata),
        .AHB_HBURST(3'b000), .AHB_HPROT(4'b0011), .AHB_HSIZE(3'b010),
        .AHB_HMASTLOCK(1'b0), .AHB_HMASTER(4'h0),
        .AHB_HRDATA(rd32), .AHB_HREADY(rdy32), .AHB_HRESP(resp32), .MUL_IRQ(irq32)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the data-phase edge.
    task automatic bus_write(input bit s32, input logic [15:0] a, input logic [31:0] d);
        sel16 = !s32; sel32 = s32; trans = 2'b10; write = 1'b1; addr = {16'h0, a};
        @(posedge clk); #1;
        sel16 = 1'b0; sel32 = 1'b0; trans = 2'b00; write = 1'b0; wdata = d;
        @(posedge clk); #1;
    endtask

    // Returns in the middle of the data phase with the sampled read data.
    task automatic bus_read(input bit s32, input logic [15:0] a, output logic [31:0] d);
        sel16 = !s32; sel32 = s32; trans = 2'b10; write = 1'b0; addr = {16'h0, a};
        @(posedge clk); #1;
        sel16 = 1'b0; sel32 = 1'b0; trans = 2'b00;
        d = s32 ? rd32 : rd16;
    endtask

    task automatic rd_chk(input string tag, input bit s32, input logic [15:0] a,
                          input logic [31:0] exp);
        logic [31:0] d;
        bus_read(s32, a, d);
        chk(tag, d, exp);
    endtask

    task automatic wait_done(input string tag, input bit s32);
        logic [31:0] d;
        d = '0;
        for (int i = 0; i < 60; i++) begin
            bus_read(s32, 16'h0008, d);
            if (d[1]) break;
        end
        chk(tag, {31'd0, d[1]}, 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        int          nbusy;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_irq16", {31'd0, irq16}, 32'd0);
        chk("rst_hrdata_idle", rd16, 32'd0);
        chk("hready_resp", {29'd0, rdy16, resp16}, 32'h4);
        rd_chk("rst_opa", 0, 16'h0000, 32'h0);
        rd_chk("rst_opb", 0, 16'h0004, 32'h0);
        rd_chk("rst_ctrl", 0, 16'h0008, 32'h0);
        rd_chk("rst_reslo", 0, 16'h000C, 32'h0);
        rd_chk("rst_reshi", 0, 16'h0010, 32'h0);
        rd_chk("unmapped", 0, 16'h0014, 32'hFFFF_FFFF);

        // Unsigned 3 x 5: BUSY seen on 17 consecutive pipelined reads (edges
        // E+1..E+17), and the first non-busy read already shows DONE.
        bus_write(0, 16'h0000, 32'd3);
        bus_write(0, 16'h0004, 32'd5);
        bus_write(0, 16'h0008, 32'h01);
        nbusy = 0;
        d = '0;
        for (int i = 0; i < 40; i++) begin
            bus_read(0, 16'h0008, d);
            if (d[2]) nbusy++;
            else break;
        end
        chk("busy_cycles", nbusy, 32'd17);
        chk("status_after_u", d, 32'h02);
        rd_chk("res_u_lo", 0, 16'h000C, 32'h0000_000F);
        rd_chk("opa_readback", 0, 16'h0000, 32'd3);

        // Signed -3 x 5 with IRQ_EN; interrupt rises exactly at E+18.
        bus_write(0, 16'h0000, 32'h0000_FFFD);
        bus_write(0, 16'h0008, 32'h19);
        chk("irq_start", {31'd0, irq16}, 32'd0);
        repeat (17) @(posedge clk);
        #1 chk("irq_e17", {31'd0, irq16}, 32'd0);
        @(posedge clk);
        #1 chk("irq_e18", {31'd0, irq16}, 32'd1);
        rd_chk("res_s_lo", 0, 16'h000C, 32'hFFFF_FFF1);
        rd_chk("res_s_hi", 0, 16'h0010, 32'h0);
        rd_chk("status_s", 0, 16'h0008, 32'h1A);
        bus_write(0, 16'h0008, 32'h12);
        chk("irq_cleared", {31'd0, irq16}, 32'd0);
        rd_chk("status_clr", 0, 16'h0008, 32'h10);

        // WIDTH=16 corners
        bus_write(0, 16'h0000, 32'h0000_FFFF);
        bus_write(0, 16'h0004, 32'h0000_FFFF);
        bus_write(0, 16'h0008, 32'h01);
        wait_done("done_u16max", 0);
        rd_chk("u16max_lo", 0, 16'h000C, 32'hFFFE_0001);
        bus_write(0, 16'h0000, 32'h0000_8000);
        bus_write(0, 16'h0004, 32'h0000_8000);
        bus_write(0, 16'h0008, 32'h09);
        wait_done("done_s16min", 0);
        rd_chk("s16min_lo", 0, 16'h000C, 32'h4000_0000);

        // WIDTH=32
        bus_write(1, 16'h0000, 32'h8000_0000);
        bus_write(1, 16'h0004, 32'h8000_0000);
        bus_write(1, 16'h0008, 32'h09);
        wait_done("done_s32min", 1);
        rd_chk("s32min_hi", 1, 16'h0010, 32'h4000_0000);
        rd_chk("s32min_lo", 1, 16'h000C, 32'h0);
        bus_write(1, 16'h0000, 32'hFFFF_FFFF);
        bus_write(1, 16'h0004, 32'hFFFF_FFFF);
        bus_write(1, 16'h0008, 32'h01);
        wait_done("done_u32max", 1);
        rd_chk("u32max_hi", 1, 16'h0010, 32'hFFFF_FFFE);
        rd_chk("u32max_lo", 1, 16'h000C, 32'h0000_0001);
        bus_write(1, 16'h0000, 32'hFFFF_FFFD);
        bus_write(1, 16'h0004, 32'd5);
        bus_write(1, 16'h0008, 32'h09);
        wait_done("done_s32neg", 1);
        rd_chk("s32neg_hi", 1, 16'h0010, 32'hFFFF_FFFF);
        rd_chk("s32neg_lo", 1, 16'h000C, 32'hFFFF_FFF1);

        // Writes while busy are ignored; RES holds the old value until FIN.
        bus_write(0, 16'h0000, 32'd6);
        bus_write(0, 16'h0004, 32'd7);
        bus_write(0, 16'h0008, 32'h01);
        bus_write(0, 16'h0000, 32'd7);
        bus_write(0, 16'h0008, 32'h09);
        rd_chk("res_held", 0, 16'h000C, 32'h4000_0000);
        wait_done("done_busywr", 0);
        rd_chk("opa_unchanged", 0, 16'h0000, 32'd6);
        rd_chk("res_busywr", 0, 16'h000C, 32'd42);
        rd_chk("ctrl_unchanged", 0, 16'h0008, 32'h02);
        bus_write(0, 16'h0008, 32'h02);
        repeat (30) @(posedge clk);
        #1;
        rd_chk("single_done", 0, 16'h0008, 32'h00);

        // Reset during RUN
        bus_write(0, 16'h0000, 32'd3);
        bus_write(0, 16'h0008, 32'h01);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_run_hrdata", rd16, 32'd0);
        rd_chk("rst_run_status", 0, 16'h0008, 32'h00);
        rd_chk("rst_run_reslo", 0, 16'h000C, 32'h0);
        rd_chk("rst_run_opa", 0, 16'h0000, 32'h0);
        rd_chk("rst_run_reshi32", 1, 16'h0010, 32'h0);
        repeat (25) @(posedge clk);
        #1;
        rd_chk("rst_run_nodone", 0, 16'h0008, 32'h00);

        bus_write(0, 16'h0000, 32'd3);
        bus_write(0, 16'h0004, 32'd5);
`ifdef MUL_ACCEL_ACCUMULATE_EN
        bus_write(0, 16'h0008, 32'h21);
        wait_done("done_acc1", 0);
        bus_write(0, 16'h0008, 32'h21);
        wait_done("done_acc2", 0);
        rd_chk("acc_status", 0, 16'h0008, 32'h22);
        rd_chk("acc_reslo", 0, 16'h000C, 32'h1E);
        bus_write(0, 16'h000C, 32'h0);
        rd_chk("acc_clear", 0, 16'h000C, 32'h0);
`else
        bus_write(0, 16'h0008, 32'h20);
        rd_chk("noacc_bit5", 0, 16'h0008, 32'h00);
        bus_write(0, 16'h0008, 32'h21);
        wait_done("done_noacc1", 0);
        bus_write(0, 16'h0008, 32'h21);
        wait_done("done_noacc2", 0);
        rd_chk("noacc_reslo", 0, 16'h000C, 32'h0F);
        bus_write(0, 16'h000C, 32'h0);
        rd_chk("noacc_reslo_wr", 0, 16'h000C, 32'h0F);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
